fsk_bit_sync: RTL and testbench

- Downstream of the FSK demodulator. Consumes its raw recovered bit stream (the demodulator's registered `dout`).
- Deglitches the stream, recovers bit timing and samples each bit at mid-bit.
- Deframes async characters (1 start, DATA_BITS data LSB-first, 1 stop) into parallel bytes with a valid strobe and error flags.
- Runs entirely on clk_1M.

---
 rtl/fsk_bit_sync.sv | 220 ++++++++++++++++++++++
 tb/tb_fsk_bit_sync.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsk_bit_sync.sv
// rtl/fsk_bit_sync.sv - deglitch, bit-timing recovery and async character deframing of demodulated FSK
`timescale 1ns/1ps
module fsk_bit_sync #(
    parameter int BIT_PERIOD = 100,
    parameter int GLITCH_LEN = 8,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk_1M,
    input  logic                 rst,
    input  logic                 demod_in,
    output logic                 line_level,
    output logic                 bit_out,
    output logic                 bit_strobe,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 byte_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int HALF = BIT_PERIOD / 2;
    localparam int CW   = $clog2(BIT_PERIOD);
    localparam int GW   = $clog2(GLITCH_LEN + 1);
    localparam int IW   = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync1_d, sync2_q, sync2_d;
    logic [GW-1:0]        gcnt_q, gcnt_d;
    logic                 line_q, line_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sreg_q, sreg_d;
    logic                 bit_out_q, bit_out_d;
    logic                 bit_strobe_q, bit_strobe_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 pend_ferr_q, pend_ferr_d;
    logic                 unread_q, unread_d;
    logic [CW-1:0]        rd_cnt_q, rd_cnt_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic                 line_edge, line_fall;

    // Synchronizer and glitch filter: level changes only after GLITCH_LEN stable mismatching cycles
    always_comb begin
        sync1_d = demod_in;
        sync2_d = sync1_q;
        gcnt_d  = '0;
        line_d  = line_q;
        if (sync2_q != line_q) begin
            if (gcnt_q == GW'(GLITCH_LEN - 1)) begin
                line_d = sync2_q;
            end else begin
                gcnt_d = gcnt_q + GW'(1);
            end
        end
        line_edge = (line_d != line_q);
        line_fall = line_q & ~line_d;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        sreg_d       = sreg_q;
        bit_out_d    = bit_out_q;
        bit_strobe_d = 1'b0;
        pend_valid_d = 1'b0;
        pend_ferr_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (line_fall) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    bit_strobe_d = 1'b1;
                    bit_out_d    = line_q;
                    cnt_d        = '0;
                    idx_d        = '0;
                    state_d      = line_q ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(BIT_PERIOD - 1)) begin
                    bit_strobe_d = 1'b1;
                    bit_out_d    = line_q;
                    sreg_d       = {line_q, sreg_q[DATA_BITS-1:1]};
                    cnt_d        = '0;
                    idx_d        = idx_q + IW'(1);
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        state_d = S_STOP;
                    end
                end else if (line_edge) begin
                    // A bit boundary seen mid-bit puts the next sample half a bit later
                    cnt_d = CW'(HALF);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CW'(BIT_PERIOD - 1)) begin
                    bit_strobe_d = 1'b1;
                    bit_out_d    = line_q;
                    cnt_d        = '0;
                    if (line_q) begin
                        pend_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        pend_ferr_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                if (line_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output stage and consumer read window tracking
    always_comb begin
        data_out_d   = pend_valid_q ? sreg_q : data_out_q;
        byte_valid_d = pend_valid_q;
        frame_err_d  = pend_ferr_q;
        busy_d       = (state_d != S_IDLE);
        unread_d     = unread_q;
        rd_cnt_d     = rd_cnt_q;
        overrun_d    = overrun_q;
        if (byte_valid_d) begin
            if (unread_q) begin
                overrun_d = 1'b1;
            end
            unread_d = 1'b1;
            rd_cnt_d = '0;
        end else if (unread_q) begin
            if (rd_cnt_q == CW'(BIT_PERIOD - 1)) begin
                unread_d = 1'b0;
                rd_cnt_d = '0;
            end else begin
                rd_cnt_d = rd_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_1M or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            gcnt_q       <= '0;
            line_q       <= 1'b1;
            cnt_q        <= '0;
            idx_q        <= '0;
            sreg_q       <= '0;
            bit_out_q    <= 1'b1;
            bit_strobe_q <= 1'b0;
            data_out_q   <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_ferr_q  <= 1'b0;
            unread_q     <= 1'b0;
            rd_cnt_q     <= '0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            gcnt_q       <= gcnt_d;
            line_q       <= line_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sreg_q       <= sreg_d;
            bit_out_q    <= bit_out_d;
            bit_strobe_q <= bit_strobe_d;
            data_out_q   <= data_out_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            pend_valid_q <= pend_valid_d;
            pend_ferr_q  <= pend_ferr_d;
            unread_q     <= unread_d;
            rd_cnt_q     <= rd_cnt_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign line_level = line_q;
    assign bit_out    = bit_out_q;
    assign bit_strobe = bit_strobe_q;
    assign data_out   = data_out_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_fsk_bit_sync.sv
// tb/tb_fsk_bit_sync.sv - scoreboard bench for fsk_bit_sync
`timescale 1ns/1ps
module tb_fsk_bit_sync;

    logic       clk_1M = 1'b0;
    logic       rst = 1'b1;
    logic       demod_in = 1'b1;
    logic       line_level, bit_out, bit_strobe, byte_valid, frame_err, overrun, busy;
    logic [7:0] data_out;

    fsk_bit_sync #(.BIT_PERIOD(100), .GLITCH_LEN(8), .DATA_BITS(8)) dut (
        .clk_1M     (clk_1M),
        .rst        (rst),
        .demod_in   (demod_in),
        .line_level (line_level),
        .bit_out    (bit_out),
        .bit_strobe (bit_strobe),
        .data_out   (data_out),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #500 clk_1M = ~clk_1M;

    int cyc = 0;
    always @(posedge clk_1M) cyc <= cyc + 1;

    // kind: 0 = bit_strobe (val = bit_out), 1 = byte_valid (val = data_out), 2 = frame_err (val = data_out)
    typedef struct {
        int kind;
        int cyc;
        int val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  toggles = 0;
    logic ll_prev = 1'b1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input int k, input int c, input int v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    function automatic void exp_frame(input int t, input logic [7:0] d, input logic stopv, input logic [7:0] prev);
        logic [9:0] fr;
        fr = {stopv, d, 1'b0};
        for (int b = 0; b < 10; b++) push(0, t + 60 + 100 * b, int'(fr[b]));
        if (stopv) push(1, t + 961, int'(d));
        else       push(2, t + 961, int'(prev));
    endfunction

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: kind %0d value %0d at cycle %0d, none required", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            chk("event_value", val, e.val);
        end
    endtask

    always @(negedge clk_1M) begin
        if (line_level !== ll_prev) toggles++;
        ll_prev = line_level;
        if (!rst) begin
            if (bit_strobe) check_ev(0, int'(bit_out));
            if (byte_valid) check_ev(1, int'(data_out));
            if (frame_err)  check_ev(2, int'(data_out));
        end
    end

    task automatic ticks(input int n);
        repeat (n) @(posedge clk_1M);
        #1;
    endtask

    task automatic send_char(input logic [7:0] d, input int per, input logic stopv, input int glitch);
        logic [9:0] fr;
        fr = {stopv, d, 1'b0};
        for (int b = 0; b < 10; b++) begin
            demod_in = fr[b];
            if (glitch > 0) begin
                ticks(20);
                demod_in = ~fr[b];
                ticks(glitch);
                demod_in = fr[b];
                ticks(per - 20 - glitch);
            end else begin
                ticks(per);
            end
        end
    endtask

    initial begin
        int         t;
        int         t0;
        logic       seen;
        logic [9:0] fr;
        int         offs[10] = '{60, 160, 260, 360, 460, 580, 680, 780, 880, 980};
        int         bits[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};

        ticks(3);
        chk("rst_line_level", int'(line_level), 1);
        chk("rst_bit_out", int'(bit_out), 1);
        chk("rst_data_out", int'(data_out), 0);
        chk("rst_bit_strobe", int'(bit_strobe), 0);
        chk("rst_byte_valid", int'(byte_valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        seen = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            ticks(1);
            if (busy) seen = 1'b1;
        end
        chk("idle_busy_seen", int'(seen), 0);

        t = cyc;
        exp_frame(t, 8'hA5, 1'b1, 8'h00);
        send_char(8'hA5, 100, 1'b1, 0);
        ticks(100);
        chk("a5_data_out", int'(data_out), 8'hA5);

        t0 = toggles;
        seen = 1'b0;
        demod_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ticks(1);
            if (busy) seen = 1'b1;
        end
        demod_in = 1'b1;
        for (int i = 0; i < 50; i++) begin
            ticks(1);
            if (busy) seen = 1'b1;
        end
        chk("idle_glitch_toggles", toggles - t0, 0);
        chk("idle_glitch_busy", int'(seen), 0);

        t0 = toggles;
        t = cyc;
        exp_frame(t, 8'h3C, 1'b1, 8'h00);
        send_char(8'h3C, 100, 1'b1, 7);
        ticks(100);
        chk("glitchy_3c_toggles", toggles - t0, 4);
        chk("glitchy_3c_data_out", int'(data_out), 8'h3C);

        t = cyc;
        exp_frame(t, 8'h55, 1'b0, 8'h3C);
        send_char(8'h55, 100, 1'b0, 0);
        ticks(2000);
        chk("break_busy", int'(busy), 1);
        chk("break_data_out", int'(data_out), 8'h3C);
        demod_in = 1'b1;
        ticks(20);
        chk("break_end_busy", int'(busy), 0);

        t = cyc;
        for (int b = 0; b < 10; b++) push(0, t + offs[b], bits[b]);
        push(1, t + 981, 8'hF0);
        send_char(8'hF0, 104, 1'b1, 0);
        ticks(100);
        chk("stretch_f0_data_out", int'(data_out), 8'hF0);

        t = cyc;
        push(0, t + 60, 1);
        demod_in = 1'b0;
        ticks(30);
        demod_in = 1'b1;
        ticks(100);
        chk("false_start_busy", int'(busy), 0);

        t = cyc;
        exp_frame(t, 8'h01, 1'b1, 8'h00);
        exp_frame(t + 1000, 8'h02, 1'b1, 8'h00);
        send_char(8'h01, 100, 1'b1, 0);
        send_char(8'h02, 100, 1'b1, 0);
        ticks(100);
        chk("b2b_overrun", int'(overrun), 0);
        chk("b2b_data_out", int'(data_out), 8'h02);

        t = cyc;
        fr = {1'b1, 8'h3A, 1'b0};
        for (int b = 0; b < 5; b++) push(0, t + 60 + 100 * b, int'(fr[b]));
        for (int b = 0; b < 5; b++) begin
            demod_in = fr[b];
            ticks(100);
        end
        demod_in = fr[5];
        ticks(20);
        chk("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        demod_in = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_line_level", int'(line_level), 1);
        chk("mid_rst_bit_out", int'(bit_out), 1);
        chk("mid_rst_data_out", int'(data_out), 0);
        ticks(5);
        rst = 1'b0;
        ticks(1200);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_overrun", int'(overrun), 0);
        chk("exp_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
